// File: rtl/cmsdk_ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane decode used by the CMSDK SRAM bridge.
package cmsdk_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Sizes above a word still map onto the full 32-bit lane set.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/cmsdk_ahb_sram_bridge_if.sv
// AHB-Lite slave-side bus bundle for the CMSDK SRAM bridge.
interface cmsdk_ahb_sram_bridge_if #(parameter int AW = 16);
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/cmsdk_ahb_sram_wbuf.sv
// One-entry write buffer: holds a write displaced by a read and merges its bytes into read data.
module cmsdk_ahb_sram_wbuf #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          capture,
  input  logic          drain,
  input  logic [AW-3:0] cap_addr,
  input  logic [3:0]    cap_lanes,
  input  logic [31:0]   cap_data,
  input  logic [AW-3:0] rd_addr,
  input  logic [31:0]   sram_rdata,
  output logic          buf_valid,
  output logic [AW-3:0] buf_addr,
  output logic [3:0]    buf_lanes,
  output logic [31:0]   buf_data,
  output logic [31:0]   rd_data
);

  logic hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_lanes <= '0;
      buf_data  <= '0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_addr  <= cap_addr;
      buf_lanes <= cap_lanes;
      buf_data  <= cap_data;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  assign hit = buf_valid && (buf_addr == rd_addr);

  // The SRAM still holds stale bytes for any lane the buffer has not yet drained.
  always_comb begin
    rd_data = sram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (hit && buf_lanes[i]) rd_data[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/cmsdk_ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite to CMSDK synchronous SRAM bridge with a one-entry write buffer.
module cmsdk_ahb_sram_bridge
  import cmsdk_ahb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  cmsdk_ahb_sram_bridge_if.slave  ahb,
  input  logic [31:0]             SRAMRDATA,
  output logic [AW-3:0]           SRAMADDR,
  output logic [31:0]             SRAMWDATA,
  output logic [3:0]              SRAMWEN,
  output logic                    SRAMCS
);

  logic          accept, rd_acc, wr_acc;
  logic          dp_rd, dp_wr;
  logic [AW-3:0] dp_addr;
  logic [3:0]    dp_lanes;
  logic          buf_capture, buf_drain;
  logic          buf_valid;
  logic [AW-3:0] buf_addr;
  logic [3:0]    buf_lanes;
  logic [31:0]   buf_data;
  logic [31:0]   merged_rdata;

  assign accept = ahb.HSEL && ahb.HREADY &&
                  ((ahb.HTRANS == HTRANS_NONSEQ) || (ahb.HTRANS == HTRANS_SEQ));
  assign rd_acc = accept && !ahb.HWRITE;
  assign wr_acc = accept && ahb.HWRITE;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_rd    <= 1'b0;
      dp_wr    <= 1'b0;
      dp_addr  <= '0;
      dp_lanes <= '0;
    end else if (ahb.HREADY) begin
      dp_rd    <= rd_acc;
      dp_wr    <= wr_acc;
      dp_addr  <= ahb.HADDR[AW-1:2];
      dp_lanes <= lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
    end
  end

  // Reads own the port so read data is ready in the first data-phase cycle;
  // a write that collides with one is parked and drained on the next idle slot.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = ahb.HADDR[AW-1:2];
    SRAMWDATA = 32'h0;
    buf_drain = 1'b0;
    if (rd_acc) begin
      SRAMCS = 1'b1;
    end else if (dp_wr) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = dp_lanes;
      SRAMADDR  = dp_addr;
      SRAMWDATA = ahb.HWDATA;
    end else if (buf_valid) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = buf_lanes;
      SRAMADDR  = buf_addr;
      SRAMWDATA = buf_data;
      buf_drain = 1'b1;
    end
  end

  assign buf_capture = dp_wr && rd_acc;

  cmsdk_ahb_sram_wbuf #(.AW(AW)) u_wbuf (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .capture    (buf_capture),
    .drain      (buf_drain),
    .cap_addr   (dp_addr),
    .cap_lanes  (dp_lanes),
    .cap_data   (ahb.HWDATA),
    .rd_addr    (dp_addr),
    .sram_rdata (SRAMRDATA),
    .buf_valid  (buf_valid),
    .buf_addr   (buf_addr),
    .buf_lanes  (buf_lanes),
    .buf_data   (buf_data),
    .rd_data    (merged_rdata)
  );

  assign ahb.HRDATA    = dp_rd ? merged_rdata : 32'h0;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

endmodule

// File: tb/tb_cmsdk_ahb_sram_bridge.sv
// Directed plus randomized bench for the AHB SRAM bridge against a byte-level memory model.
module tb_cmsdk_ahb_sram_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] SRAMRDATA;
  logic [13:0] SRAMADDR;
  logic [31:0] SRAMWDATA;
  logic [3:0]  SRAMWEN;
  logic        SRAMCS;

  cmsdk_ahb_sram_bridge_if #(.AW(16)) bus ();

  cmsdk_ahb_sram_bridge #(.AW(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ahb       (bus),
    .SRAMRDATA (SRAMRDATA),
    .SRAMADDR  (SRAMADDR),
    .SRAMWDATA (SRAMWDATA),
    .SRAMWEN   (SRAMWEN),
    .SRAMCS    (SRAMCS)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  logic [31:0] sram_mem [0:16383];
  logic [7:0]  ref_mem  [0:65535];

  // Synchronous SRAM: registered read of the pre-write contents.
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      SRAMRDATA <= sram_mem[SRAMADDR];
      for (int i = 0; i < 4; i++)
        if (SRAMWEN[i]) sram_mem[SRAMADDR][8*i +: 8] = SRAMWDATA[8*i +: 8];
    end
  end

  logic        pend_rd, pend_wr, nxt_rd, nxt_wr;
  logic [15:0] pend_addr, nxt_addr;
  logic [2:0]  pend_size, nxt_size;
  logic [31:0] pend_wdata, nxt_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] bench_lanes(input logic [2:0] size, input logic [15:0] addr);
    int nbytes, base;
    nbytes = (size >= 3'd2) ? 4 : (1 << size);
    base   = int'(addr[1:0]) & ~(nbytes - 1);
    return 4'(((1 << nbytes) - 1) << base);
  endfunction

  function automatic logic [31:0] ref_word(input logic [15:0] addr);
    int a;
    a = int'({addr[15:2], 2'b00});
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  task automatic ref_set_word(input logic [15:0] addr, input logic [31:0] w);
    int a;
    a = int'({addr[15:2], 2'b00});
    for (int i = 0; i < 4; i++) ref_mem[a+i] = w[8*i +: 8];
  endtask

  task automatic preload(input logic [15:0] addr, input logic [31:0] w);
    sram_mem[addr[15:2]] = w;
    ref_set_word(addr, w);
  endtask

  task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [15:0] addr,
                                input logic [31:0] wdata);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
    bus.HREADY = 1'b1;
    bus.HWDATA = pend_wr ? pend_wdata : $urandom();
    nxt_rd    = sel && trans[1] && !wr;
    nxt_wr    = sel && trans[1] && wr;
    nxt_addr  = addr;
    nxt_size  = size;
    nxt_wdata = wdata;
  endtask

  task automatic check_output();
    logic [3:0] ln;
    int a;
    @(negedge HCLK);
    check("hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    check("hresp", {31'b0, bus.HRESP}, 32'h0);
    if (pend_rd) check("hrdata", bus.HRDATA, ref_word(pend_addr));
    else         check("hrdata_idle", bus.HRDATA, 32'h0);
    if (pend_wr) begin
      ln = bench_lanes(pend_size, pend_addr);
      a  = int'({pend_addr[15:2], 2'b00});
      for (int i = 0; i < 4; i++)
        if (ln[i]) ref_mem[a+i] = bus.HWDATA[8*i +: 8];
    end
  endtask

  task automatic advance();
    @(posedge HCLK);
    #1;
    pend_rd    = nxt_rd;
    pend_wr    = nxt_wr;
    pend_addr  = nxt_addr;
    pend_size  = nxt_size;
    pend_wdata = nxt_wdata;
  endtask

  task automatic cycle(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [15:0] addr, input logic [31:0] wdata);
    apply_stimulus(sel, trans, wr, size, addr, wdata);
    check_output();
    advance();
  endtask

  // A write data phase must never coexist with a parked write.
  always @(negedge HCLK) begin
    if (HRESETn && dut.dp_wr) check("inv_buf_empty", {31'b0, dut.buf_valid}, 32'h0);
  end

  logic [31:0] w;
  logic [15:0] ra;
  logic [2:0]  rs;

  initial begin
    HRESETn = 1'b0;
    pend_rd = 0; pend_wr = 0; pend_addr = '0; pend_size = '0; pend_wdata = '0;
    nxt_rd = 0; nxt_wr = 0; nxt_addr = '0; nxt_size = '0; nxt_wdata = '0;
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWRITE = 0; bus.HSIZE = 3'd0;
    bus.HADDR = '0; bus.HWDATA = '0; bus.HREADY = 1'b1;
    SRAMRDATA = '0;
    for (int i = 0; i < 16384; i++) preload(16'(i * 4), $urandom());
    preload(16'h0200, 32'h11223344);
    preload(16'h0300, 32'h11111111);
    preload(16'h0500, 32'h5A5A7788);
    preload(16'h0600, 32'h0BADF00D);

    repeat (2) @(posedge HCLK);
    #1;
    check("rst_sramcs", {31'b0, SRAMCS}, 32'h0);
    check("rst_sramwen", {28'b0, SRAMWEN}, 32'h0);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    check("rst_hresp", {31'b0, bus.HRESP}, 32'h0);
    HRESETn = 1'b1;
    cycle(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);

    // Word write, idle, read back
    cycle(1, 2'b10, 1, 3'd2, 16'h0100, 32'hDEADBEEF);
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t1_cs", {31'b0, SRAMCS}, 32'h1);
    check("t1_wen", {28'b0, SRAMWEN}, 32'hF);
    check("t1_addr", {18'b0, SRAMADDR}, 32'h40);
    check("t1_wdata", SRAMWDATA, 32'hDEADBEEF);
    advance();
    apply_stimulus(1, 2'b10, 0, 3'd2, 16'h0100, 32'h0);
    check_output();
    check("t1_rd_cs", {31'b0, SRAMCS}, 32'h1);
    check("t1_rd_wen", {28'b0, SRAMWEN}, 32'h0);
    advance();
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t1_hrdata", bus.HRDATA, 32'hDEADBEEF);
    advance();

    // Byte write into lane 3, then word read
    cycle(1, 2'b10, 1, 3'd0, 16'h0203, 32'hA5000000);
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t2_wen", {28'b0, SRAMWEN}, 32'h8);
    check("t2_addr", {18'b0, SRAMADDR}, 32'h80);
    advance();
    cycle(1, 2'b10, 0, 3'd2, 16'h0200, 32'h0);
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t2_hrdata", bus.HRDATA, 32'hA5223344);
    advance();

    // Write then back-to-back read of the same word: merged, drained afterwards
    cycle(1, 2'b10, 1, 3'd2, 16'h0300, 32'hCAFEF00D);
    apply_stimulus(1, 2'b10, 0, 3'd2, 16'h0300, 32'h0);
    check_output();
    check("t3_rd_wen", {28'b0, SRAMWEN}, 32'h0);
    check("t3_rd_addr", {18'b0, SRAMADDR}, 32'hC0);
    advance();
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t3_hrdata", bus.HRDATA, 32'hCAFEF00D);
    check("t3_drain_wen", {28'b0, SRAMWEN}, 32'hF);
    check("t3_drain_addr", {18'b0, SRAMADDR}, 32'hC0);
    check("t3_drain_wdata", SRAMWDATA, 32'hCAFEF00D);
    advance();

    // Buffer held across a burst of reads, one drain on the idle cycle
    cycle(1, 2'b10, 1, 3'd2, 16'h0400, 32'h600DCAFE);
    apply_stimulus(1, 2'b10, 0, 3'd2, 16'h0404, 32'h0);
    check_output();
    advance();
    apply_stimulus(1, 2'b11, 0, 3'd2, 16'h0408, 32'h0);
    check_output();
    check("t4_hold_wen0", {28'b0, SRAMWEN}, 32'h0);
    check("t4_rd_addr0", {18'b0, SRAMADDR}, 32'h102);
    advance();
    apply_stimulus(1, 2'b11, 0, 3'd2, 16'h040C, 32'h0);
    check_output();
    check("t4_hold_wen1", {28'b0, SRAMWEN}, 32'h0);
    advance();
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t4_drain_cs", {31'b0, SRAMCS}, 32'h1);
    check("t4_drain_wen", {28'b0, SRAMWEN}, 32'hF);
    check("t4_drain_addr", {18'b0, SRAMADDR}, 32'h100);
    advance();
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t4_single_drain", {31'b0, SRAMCS}, 32'h0);
    advance();

    // Half write upper lanes, back-to-back read
    cycle(1, 2'b10, 1, 3'd1, 16'h0502, 32'hBEEF0000);
    apply_stimulus(1, 2'b10, 0, 3'd2, 16'h0500, 32'h0);
    check_output();
    advance();
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t5_hrdata", bus.HRDATA, 32'hBEEF7788);
    check("t5_drain_wen", {28'b0, SRAMWEN}, 32'hC);
    advance();

    // Reset with a parked write: it is lost
    cycle(1, 2'b10, 1, 3'd2, 16'h0600, 32'h12345678);
    apply_stimulus(1, 2'b10, 0, 3'd2, 16'h0604, 32'h0);
    check_output();
    advance();
    apply_stimulus(1, 2'b11, 0, 3'd2, 16'h0608, 32'h0);
    check_output();
    check("t6_buf_valid", {31'b0, dut.buf_valid}, 32'h1);
    bus.HSEL = 0;
    bus.HTRANS = 2'b00;
    HRESETn = 1'b0;
    #1;
    check("t6_rst_cs", {31'b0, SRAMCS}, 32'h0);
    check("t6_rst_wen", {28'b0, SRAMWEN}, 32'h0);
    check("t6_rst_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    pend_rd = 0; pend_wr = 0; nxt_rd = 0; nxt_wr = 0;
    ref_set_word(16'h0600, 32'h0BADF00D);
    cycle(1, 2'b10, 0, 3'd2, 16'h0600, 32'h0);
    apply_stimulus(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    check_output();
    check("t6_old_value", bus.HRDATA, 32'h0BADF00D);
    advance();

    // Random traffic over a small window so merges and drains collide often
    for (int n = 0; n < 600; n++) begin
      rs = 3'($urandom_range(0, 2));
      ra = 16'($urandom_range(0, 127));
      if (rs == 3'd1) ra[0] = 1'b0;
      if (rs == 3'd2) ra[1:0] = 2'b00;
      w = $urandom();
      cycle(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            rs, ra, w);
    end
    cycle(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);
    cycle(1, 2'b00, 0, 3'd0, 16'h0000, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmsdk_ahb_sram_bridge.md
Name: cmsdk_ahb_sram_bridge

Overview:
- AHB-Lite slave that drives a CMSDK synchronous SRAM/BlockRAM array (CS, WREN[3:0], word address, 1-cycle pipelined read data).
- Sits between the bus matrix and cmsdk_fpga_sram; zero wait states for all transfers.
- Uses a one-entry write buffer with read-data merging, so a read issued in the data phase of a write sees the new bytes.

Parameters:
- AW, 16, byte address width; SRAM word address is AW-2 bits.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  AW  byte address.
- HTRANS  input  2  transfer type; bit1 set means NONSEQ/SEQ.
- HSIZE  input  3  0 byte, 1 half, 2 word.
- HWRITE  input  1  write when 1.
- HWDATA  input  32  write data, data phase.
- HREADY  input  1  bus ready.
- HREADYOUT  output  1  always 1.
- HRESP  output  1  always 0 (OKAY).
- HRDATA  output  32  read data, data phase.
- SRAMRDATA  input  32  SRAM read data, one cycle after CS.
- SRAMADDR  output  AW-2  SRAM word address.
- SRAMWDATA  output  32  SRAM write data.
- SRAMWEN  output  4  byte write enables.
- SRAMCS  output  1  SRAM chip select.

Behaviour:
- Accept = HSEL & HREADY & HTRANS[1]; rd_acc = accept & ~HWRITE; wr_acc = accept & HWRITE.
- Lane decode: byte gives one lane by HADDR[1:0]; half gives lanes {1:0} or {3:2} by HADDR[1]; word and HSIZE>2 give 4'b1111. HADDR[0] is ignored for half.
- Data-phase regs, loaded whenever HREADY=1:
  - dp_rd, dp_wr (cleared when not accepted); dp_addr = HADDR[AW-1:2]; dp_lanes.
- Write buffer regs: buf_valid, buf_addr, buf_lanes, buf_data.
- SRAM port priority, evaluated each cycle:
  1. rd_acc: SRAMCS=1, SRAMWEN=0, SRAMADDR=HADDR[AW-1:2].
  2. Else dp_wr: direct write. SRAMCS=1, SRAMWEN=dp_lanes, SRAMADDR=dp_addr, SRAMWDATA=HWDATA.
  3. Else buf_valid: drain. SRAMCS=1, SRAMWEN=buf_lanes, SRAMADDR=buf_addr, SRAMWDATA=buf_data; buf_valid clears at the clock edge.
  4. Else SRAMCS=0, SRAMWEN=0.
- dp_wr & rd_acc together: the write is captured into the buffer (buf_valid=1, buf_addr=dp_addr, buf_lanes=dp_lanes, buf_data=HWDATA).
- Invariant: buf_valid is never 1 during a write data phase, because the write's own address-phase cycle is not a read and drains the buffer. The bench asserts this.
- Read data phase (dp_rd): HRDATA byte i = buf_data byte i if buf_valid & buf_addr==dp_addr & buf_lanes[i]; otherwise SRAMRDATA byte i. Merge uses buffer contents present in that cycle.
- Read latency: data valid in the first data-phase cycle. HRDATA is a don't-care outside dp_rd and is driven 0.
- HREADY low while a data phase is pending: dp regs hold; SRAM port may still drain the buffer.
- Reset values: dp_rd=0, dp_wr=0, buf_valid=0, other regs 0. Outputs: SRAMCS=0, SRAMWEN=0, HRDATA=0, HREADYOUT=1, HRESP=0.
- Reset mid-operation: any buffered write is discarded.

Decomposition:
- Shared package cmsdk_ahb_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and HSIZE encodings.
  - the lane-decode function (size, addr[1:0]) -> 4-bit mask.
- One sub-module is natural: cmsdk_ahb_sram_wbuf. It contains the buffer registers, the address compare and the byte merge mux. Top level keeps the data-phase regs and SRAM port arbitration.

Test Plan:
- Word write 0x100 = 0xDEADBEEF, then IDLE, then read 0x100 -> direct write with SRAMWEN=4'hF in write data phase; HRDATA=0xDEADBEEF; HREADYOUT=1 throughout.
- Byte write 0x0A5 to 0x203 at HSIZE=0, then word read 0x200 (mem was 0x11223344) -> SRAMWEN=4'b1000; HRDATA=0xA5223344.
- Write 0x300 = 0xCAFEF00D followed back-to-back by read 0x300 -> write buffered, SRAM returns old value, HRDATA=0xCAFEF00D via merge; drain occurs in the next non-read cycle.
- Write 0x400, then reads 0x404, 0x408, 0x40C back-to-back, then IDLE -> buffer held across all reads, reads unmerged; single drain with SRAMADDR=0x100 on the IDLE cycle.
- Half write 0xBEEF to 0x502, then back-to-back read 0x500 -> SRAMWEN=4'b1100 after drain; HRDATA[31:16]=0xBEEF, low half from memory.
- Assert HRESETn low with buf_valid=1 -> SRAMCS=0 and SRAMWEN=0 immediately; after release, a read of that address returns the old memory value.
